// File: rtl/ysyx_22041752_dsram_resp.sv
// Data-SRAM responder: byte-masked writes, latency-parameterised reads, range/lane checks.
// Optional access counters are built when YSYX_22041752_DSRAM_CNT_EN is defined.
module ysyx_22041752_dsram_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_sram_en_i,
    input  logic [7:0]  data_sram_wen_i,
    input  logic [63:0] data_sram_addr_i,
    input  logic [63:0] data_sram_wdata_i,
    output logic [63:0] data_sram_rdata_o,
    output logic        data_sram_rvalid_o,
    output logic        data_sram_busy_o,
    output logic        data_sram_err_o,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o
);
    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_err_q, pend_err_d;
    logic        err_q, err_d;

    logic [63:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            is_write;
    logic            in_range;
    logic            lane_cross;
    logic            wr_legal;
    logic [2:0]      off;
    logic [60:0]     rel_word;
    logic [IdxW-1:0] idx;
    logic [15:0]     lane;
    logic [63:0]     wshift;
    logic [63:0]     rd_shift;

    assign data_sram_busy_o = (state_q == StWait);
    assign accept           = data_sram_en_i & ~data_sram_busy_o;
    assign is_write         = |data_sram_wen_i;

    // BASE_ADDR is word aligned, so the word index is a difference of the upper bits.
    assign off        = data_sram_addr_i[2:0];
    assign rel_word   = data_sram_addr_i[63:3] - BASE_ADDR[63:3];
    assign idx        = rel_word[IdxW-1:0];
    assign in_range   = (data_sram_addr_i >= BASE_ADDR) && (rel_word < 61'(DEPTH_WORDS));
    assign lane       = {8'h00, data_sram_wen_i} << off;
    assign lane_cross = |lane[15:8];
    assign wr_legal   = in_range & ~lane_cross;
    assign wshift     = data_sram_wdata_i << {off, 3'b000};
    assign rd_shift   = in_range ? (mem[idx] >> {off, 3'b000}) : 64'h0;

    always_ff @(posedge clk_i) begin
        if (accept && is_write && wr_legal) begin
            for (int k = 0; k < 8; k++) begin
                if (lane[k]) begin
                    mem[idx][8*k +: 8] <= wshift[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        pend_d     = pend_q;
        pend_err_d = pend_err_q;
        err_d      = 1'b0;

        case (state_q)
            StWait: begin
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    rdata_d = pend_q;
                    err_d   = pend_err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Acceptance is only possible outside WAIT, so it may override the case above.
        if (accept) begin
            if (is_write) begin
                err_d = ~wr_legal;
            end else if (READ_LAT <= 1) begin
                state_d = StResp;
                rdata_d = rd_shift;
                err_d   = ~in_range;
            end else begin
                state_d    = StWait;
                cnt_d      = 4'(READ_LAT - 1);
                pend_d     = rd_shift;
                pend_err_d = ~in_range;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            rdata_q    <= 64'h0;
            pend_q     <= 64'h0;
            pend_err_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            pend_q     <= pend_d;
            pend_err_q <= pend_err_d;
            err_q      <= err_d;
        end
    end

    assign data_sram_rdata_o  = rdata_q;
    assign data_sram_rvalid_o = (state_q == StResp);
    assign data_sram_err_o    = err_q;

`ifdef YSYX_22041752_DSRAM_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= 32'h0;
            wr_cnt_q <= 32'h0;
        end else begin
            if (accept && !is_write && (rd_cnt_q != 32'hFFFF_FFFF)) begin
                rd_cnt_q <= rd_cnt_q + 32'h1;
            end
            if (accept && is_write && wr_legal && (wr_cnt_q != 32'hFFFF_FFFF)) begin
                wr_cnt_q <= wr_cnt_q + 32'h1;
            end
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`else
    assign rd_cnt_o = 32'h0;
    assign wr_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_22041752_dsram_resp.sv
// Self-checking bench for the data-SRAM responder: one instance at read latency 1, one at 3,
// both checked against a byte-addressed memory model.
module tb_ysyx_22041752_dsram_resp;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int unsigned NW   = 1024;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en1   = 1'b0;
    logic        en3   = 1'b0;
    logic [7:0]  wen   = 8'h00;
    logic [63:0] addr  = 64'h0;
    logic [63:0] wdata = 64'h0;

    logic [63:0] rdata1, rdata3;
    logic        rvalid1, rvalid3, busy1, busy3, err1, err3;
    logic [31:0] rdc1, wrc1, rdc3, wrc3;

    int total = 0;
    int bad   = 0;

    logic [63:0] mdl [2][NW];
    logic [63:0] exp_rd1 = 64'h0;

    always #5 clk = ~clk;

    ysyx_22041752_dsram_resp #(
        .DEPTH_WORDS (NW),
        .BASE_ADDR   (BASE),
        .READ_LAT    (1)
    ) u_dut1 (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .data_sram_en_i     (en1),
        .data_sram_wen_i    (wen),
        .data_sram_addr_i   (addr),
        .data_sram_wdata_i  (wdata),
        .data_sram_rdata_o  (rdata1),
        .data_sram_rvalid_o (rvalid1),
        .data_sram_busy_o   (busy1),
        .data_sram_err_o    (err1),
        .rd_cnt_o           (rdc1),
        .wr_cnt_o           (wrc1)
    );

    ysyx_22041752_dsram_resp #(
        .DEPTH_WORDS (NW),
        .BASE_ADDR   (BASE),
        .READ_LAT    (3)
    ) u_dut3 (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .data_sram_en_i     (en3),
        .data_sram_wen_i    (wen),
        .data_sram_addr_i   (addr),
        .data_sram_wdata_i  (wdata),
        .data_sram_rdata_o  (rdata3),
        .data_sram_rvalid_o (rvalid3),
        .data_sram_busy_o   (busy3),
        .data_sram_err_o    (err3),
        .rd_cnt_o           (rdc3),
        .wr_cnt_o           (wrc3)
    );

    // Byte-addressed reference: a write stores n = popcount(wen) bytes starting at the
    // addressed byte; it is legal only if all of them stay inside one in-range word.
    function automatic void mdl_access(input int s, input logic [7:0] w, input logic [63:0] a,
                                       input logic [63:0] d, output logic [63:0] rd,
                                       output logic er);
        logic [63:0] word_no;
        int          o;
        int          n;
        logic        inr;
        word_no = (a - BASE) >> 3;
        o       = int'(a[2:0]);
        n       = $countones(w);
        inr     = (a >= BASE) && (word_no < 64'(NW));
        rd      = 64'h0;
        er      = 1'b0;
        if (w == 8'h00) begin
            er = !inr;
            if (inr) rd = mdl[s][word_no[9:0]] >> (8 * o);
        end else if (inr && (o + n <= 8)) begin
            for (int b = 0; b < n; b++) mdl[s][word_no[9:0]][8*(o+b) +: 8] = d[8*b +: 8];
        end else begin
            er = 1'b1;
        end
    endfunction

    function automatic logic [63:0] rand_addr();
        int unsigned r;
        logic [63:0] o;
        r = $urandom_range(0, 19);
        o = 64'($urandom_range(0, 7));
        if (r < 15) return BASE + 64'(8 * $urandom_range(0, 15)) + o;
        if (r < 17) return BASE + 64'(8 * (NW - 1)) + o;
        if (r == 17) return BASE - 64'd8 + o;
        if (r == 18) return BASE + 64'(8 * NW) + o;
        return 64'hFFFF_FFFF_0000_0000 + 64'($urandom_range(0, 4095));
    endfunction

    function automatic logic [7:0] rand_wen();
        int unsigned r;
        r = $urandom_range(0, 5);
        case (r)
            0, 1:    return 8'h00;
            2:       return 8'h01;
            3:       return 8'h03;
            4:       return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rdata1 !== 64'h0) begin bad++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
        total++; if (rvalid1 !== 1'b0) begin bad++; $display("FAIL reset_rvalid1: got %b want 0", rvalid1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1: got %b want 0", busy1); end
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL reset_err1: got %b want 0", err1); end
        total++; if (rdc1 !== 32'h0 || wrc1 !== 32'h0) begin
            bad++; $display("FAIL reset_cnt1: got rd=%0d wr=%0d want 0 0", rdc1, wrc1);
        end
        total++; if (rdata3 !== 64'h0 || rvalid3 !== 1'b0 || busy3 !== 1'b0 || err3 !== 1'b0) begin
            bad++; $display("FAIL reset_dut3: got rdata=%h rv=%b busy=%b err=%b want all 0",
                            rdata3, rvalid3, busy3, err3);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_rd1 = 64'h0;
    endtask

    task automatic test_init();
        logic [63:0] rd;
        logic        er;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            en1   = 1'b1;
            en3   = 1'b1;
            wen   = 8'hff;
            addr  = BASE + 64'(8 * ((i == 16) ? (NW - 1) : i));
            wdata = {$urandom, $urandom};
            mdl_access(0, wen, addr, wdata, rd, er);
            mdl_access(1, wen, addr, wdata, rd, er);
            @(negedge clk);
            en1 = 1'b0;
            en3 = 1'b0;
            total++; if (err1 !== 1'b0 || err3 !== 1'b0) begin
                bad++; $display("FAIL init_write_err: got %b %b want 0 0", err1, err3);
            end
        end
    endtask

    task automatic test_directed_lat1();
        logic [7:0]  tw [13];
        logic [63:0] ta [13];
        logic [63:0] td [13];
        logic [63:0] rd;
        logic        er;
        logic        exp_rv = 1'b0;
        logic        exp_er = 1'b0;
        tw = '{8'hff, 8'h00, 8'h01, 8'h00, 8'h00, 8'h0f, 8'h00, 8'h00, 8'h00, 8'h00, 8'hff,
               8'h03, 8'h03};
        ta = '{64'h8000_0008, 64'h8000_0008, 64'h8000_0013, 64'h8000_0010, 64'h8000_0013,
               64'h8000_0006, 64'h8000_0000, 64'h7FFF_FFF8, 64'h8000_1FFD, 64'h8000_2000,
               64'h8000_2000, 64'h8000_0017, 64'h8000_0016};
        for (int i = 0; i < 13; i++) td[i] = {$urandom, $urandom};
        td[0] = 64'h1122_3344_5566_7788;
        td[2] = 64'h0000_0000_0000_00AB;
        for (int i = 0; i <= 13; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++; if (rvalid1 !== exp_rv) begin
                    bad++; $display("FAIL dir_rvalid op%0d: got %b want %b", i - 1, rvalid1, exp_rv);
                end
                total++; if (err1 !== exp_er) begin
                    bad++; $display("FAIL dir_err op%0d: got %b want %b", i - 1, err1, exp_er);
                end
                total++; if (rdata1 !== exp_rd1) begin
                    bad++; $display("FAIL dir_rdata op%0d: got %h want %h", i - 1, rdata1, exp_rd1);
                end
                total++; if (busy1 !== 1'b0) begin
                    bad++; $display("FAIL dir_busy op%0d: got %b want 0", i - 1, busy1);
                end
                if (i == 2) begin
                    total++; if (rdata1 !== 64'h1122_3344_5566_7788) begin
                        bad++; $display("FAIL dir_raw_full: got %h want 1122334455667788", rdata1);
                    end
                end
                if (i == 4) begin
                    total++; if (rdata1[31:24] !== 8'hAB) begin
                        bad++; $display("FAIL dir_byte3: got %h want ab", rdata1[31:24]);
                    end
                end
            end
            if (i < 13) begin
                en1   = 1'b1;
                wen   = tw[i];
                addr  = ta[i];
                wdata = td[i];
                mdl_access(0, wen, addr, wdata, rd, er);
                exp_rv = (tw[i] == 8'h00);
                exp_er = er;
                if (exp_rv) exp_rd1 = rd;
            end else begin
                en1 = 1'b0;
            end
        end
    endtask

    task automatic test_random_lat1();
        logic [63:0] rd;
        logic        er;
        logic        exp_rv = 1'b0;
        logic        exp_er = 1'b0;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++; if (rvalid1 !== exp_rv) begin
                    bad++; $display("FAIL rnd1_rvalid #%0d: got %b want %b", i, rvalid1, exp_rv);
                end
                total++; if (err1 !== exp_er) begin
                    bad++; $display("FAIL rnd1_err #%0d: got %b want %b", i, err1, exp_er);
                end
                total++; if (rdata1 !== exp_rd1) begin
                    bad++; $display("FAIL rnd1_rdata #%0d: got %h want %h", i, rdata1, exp_rd1);
                end
                total++; if (busy1 !== 1'b0) begin
                    bad++; $display("FAIL rnd1_busy #%0d: got %b want 0", i, busy1);
                end
            end
            if (i < 300) begin
                en1   = 1'b1;
                wen   = rand_wen();
                addr  = rand_addr();
                wdata = {$urandom, $urandom};
                mdl_access(0, wen, addr, wdata, rd, er);
                exp_rv = (wen == 8'h00);
                exp_er = er;
                if (exp_rv) exp_rd1 = rd;
            end else begin
                en1 = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back_lat3();
        logic [63:0] ra, rb, rc, bdata, baddr;
        logic        ea, eb, ec;
        @(negedge clk);
        en3  = 1'b1;
        wen  = 8'h00;
        addr = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
        mdl_access(1, wen, addr, 64'h0, ra, ea);
        @(negedge clk);  // T+1
        total++; if (busy3 !== 1'b1 || rvalid3 !== 1'b0) begin
            bad++; $display("FAIL b2b_t1: got busy=%b rv=%b want 1 0", busy3, rvalid3);
        end
        wen   = 8'hxx;
        addr  = 64'hxxxx_xxxx_xxxx_xxxx;
        wdata = 64'hxxxx_xxxx_xxxx_xxxx;
        @(negedge clk);  // T+2
        total++; if (busy3 !== 1'b1 || rvalid3 !== 1'b0) begin
            bad++; $display("FAIL b2b_t2: got busy=%b rv=%b want 1 0", busy3, rvalid3);
        end
        baddr = BASE + 64'(8 * $urandom_range(0, 15));
        bdata = {$urandom, $urandom};
        wen   = 8'hff;
        addr  = baddr;
        wdata = bdata;
        @(negedge clk);  // T+3
        total++; if (rvalid3 !== 1'b1 || busy3 !== 1'b0) begin
            bad++; $display("FAIL b2b_t3_ctl: got rv=%b busy=%b want 1 0", rvalid3, busy3);
        end
        total++; if (rdata3 !== ra || err3 !== ea) begin
            bad++; $display("FAIL b2b_t3_data: got %h err=%b want %h err=%b", rdata3, err3, ra, ea);
        end
        wen  = 8'h00;
        addr = rand_addr();
        mdl_access(1, wen, addr, 64'h0, rc, ec);
        @(negedge clk);  // T+4
        en3 = 1'b0;
        total++; if (busy3 !== 1'b1 || rvalid3 !== 1'b0) begin
            bad++; $display("FAIL b2b_t4: got busy=%b rv=%b want 1 0", busy3, rvalid3);
        end
        total++; if (rdata3 !== ra) begin
            bad++; $display("FAIL b2b_hold: got %h want %h", rdata3, ra);
        end
        @(negedge clk);  // T+5
        total++; if (busy3 !== 1'b1 || rvalid3 !== 1'b0) begin
            bad++; $display("FAIL b2b_t5: got busy=%b rv=%b want 1 0", busy3, rvalid3);
        end
        @(negedge clk);  // T+6
        total++; if (rvalid3 !== 1'b1 || rdata3 !== rc || err3 !== ec) begin
            bad++; $display("FAIL b2b_t6: got rv=%b %h err=%b want 1 %h err=%b",
                            rvalid3, rdata3, err3, rc, ec);
        end
        // The write presented while busy must have been dropped.
        @(negedge clk);
        en3  = 1'b1;
        wen  = 8'h00;
        addr = baddr;
        mdl_access(1, wen, addr, 64'h0, rb, eb);
        @(negedge clk);
        en3 = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rvalid3 !== 1'b1 || rdata3 !== rb || err3 !== eb) begin
            bad++; $display("FAIL b2b_ignored_write: got rv=%b %h want 1 %h", rvalid3, rdata3, rb);
        end
    endtask

    task automatic test_random_lat3();
        logic [63:0] rd;
        logic        er;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            en3   = 1'b1;
            wen   = rand_wen();
            addr  = rand_addr();
            wdata = {$urandom, $urandom};
            mdl_access(1, wen, addr, wdata, rd, er);
            @(negedge clk);
            en3 = 1'b0;
            if (wen != 8'h00) begin
                total++; if (err3 !== er || busy3 !== 1'b0 || rvalid3 !== 1'b0) begin
                    bad++; $display("FAIL rnd3_write #%0d: got err=%b busy=%b rv=%b want %b 0 0",
                                    i, err3, busy3, rvalid3, er);
                end
            end else begin
                for (int k = 1; k < 3; k++) begin
                    total++; if (busy3 !== 1'b1 || rvalid3 !== 1'b0 || err3 !== 1'b0) begin
                        bad++; $display("FAIL rnd3_wait #%0d c%0d: got busy=%b rv=%b err=%b want 1 0 0",
                                        i, k, busy3, rvalid3, err3);
                    end
                    @(negedge clk);
                end
                total++; if (rvalid3 !== 1'b1 || busy3 !== 1'b0) begin
                    bad++; $display("FAIL rnd3_resp #%0d: got rv=%b busy=%b want 1 0", i, rvalid3, busy3);
                end
                total++; if (rdata3 !== rd || err3 !== er) begin
                    bad++; $display("FAIL rnd3_data #%0d: got %h err=%b want %h err=%b",
                                    i, rdata3, err3, rd, er);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        en3  = 1'b1;
        wen  = 8'h00;
        addr = BASE + 64'd8;
        @(negedge clk);  // T+1
        en3 = 1'b0;
        total++; if (busy3 !== 1'b1) begin bad++; $display("FAIL rstmid_pre_busy: got %b want 1", busy3); end
        rst_n = 1'b0;
        #1;
        total++; if (busy3 !== 1'b0 || rvalid3 !== 1'b0 || rdata3 !== 64'h0) begin
            bad++; $display("FAIL rstmid_async: got busy=%b rv=%b rdata=%h want 0 0 0",
                            busy3, rvalid3, rdata3);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        exp_rd1 = 64'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (rvalid3 !== 1'b0 || busy3 !== 1'b0) begin
                bad++; $display("FAIL rstmid_dropped c%0d: got rv=%b busy=%b want 0 0", k, rvalid3, busy3);
            end
        end
    endtask

    task automatic test_counters();
        logic [7:0]  cw [8];
        logic [63:0] ca [8];
        logic [63:0] rd;
        logic        er;
        logic [31:0] want_rd, want_wr;
        cw = '{8'h00, 8'h00, 8'hff, 8'h00, 8'h0f, 8'h00, 8'hff, 8'h00};
        ca = '{64'h8000_0000, 64'h8000_0008, 64'h8000_0028, 64'h7FFF_FFF8, 64'h8000_0006,
               64'h8000_0010, 64'h8000_0030, 64'h8000_0018};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            en1   = 1'b1;
            wen   = cw[i];
            addr  = ca[i];
            wdata = {$urandom, $urandom};
            mdl_access(0, wen, addr, wdata, rd, er);
        end
        @(negedge clk);
        en1 = 1'b0;
        @(negedge clk);
`ifdef YSYX_22041752_DSRAM_CNT_EN
        want_rd = 32'd5;
        want_wr = 32'd2;
`else
        want_rd = 32'd0;
        want_wr = 32'd0;
`endif
        total++; if (rdc1 !== want_rd) begin bad++; $display("FAIL cnt_rd1: got %0d want %0d", rdc1, want_rd); end
        total++; if (wrc1 !== want_wr) begin bad++; $display("FAIL cnt_wr1: got %0d want %0d", wrc1, want_wr); end
        total++; if (rdc3 !== 32'h0 || wrc3 !== 32'h0) begin
            bad++; $display("FAIL cnt_dut3: got rd=%0d wr=%0d want 0 0", rdc3, wrc3);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_directed_lat1();
        test_random_lat1();
        test_back_to_back_lat3();
        test_random_lat3();
        test_reset_mid();
        test_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041752_dsram_resp.md
Name: ysyx_22041752_dsram_resp

Overview:
Data-SRAM responder that sits on the far side of the execute stage's data_sram_* request interface. It holds the core's on-chip data memory, applies byte-masked writes, and returns read data to the memory stage after a parameterised latency. It asserts busy so the pipeline stalls during multi-cycle reads, and flags out-of-range or lane-crossing accesses.

Parameters:
DEPTH_WORDS, 1024, number of 64-bit words (8 KiB).
BASE_ADDR, 64'h8000_0000, byte address of word 0.
READ_LAT, 1, cycles from request acceptance to rvalid; legal range 1..15.

Ports:
clk  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
data_sram_en  input  1  request strobe
data_sram_wen  input  8  low-aligned byte mask (8'h01/03/0f/ff); 0 means read
data_sram_addr  input  64  byte address
data_sram_wdata  input  64  write data, low-aligned (not pre-shifted)
data_sram_rdata  output  64  read data, right-shifted so bit 0 is the addressed byte
data_sram_rvalid  output  1  one-cycle pulse with rdata
data_sram_busy  output  1  responder cannot accept; requester must hold
data_sram_err  output  1  one-cycle pulse on an illegal access
rd_cnt  output  32  read count (optional feature)
wr_cnt  output  32  write count (optional feature)

Behaviour:
- Reset (reset==0, async): state=IDLE; rdata=0, rvalid=0, busy=0, err=0, counters=0. Memory array is not cleared.
- Acceptance: a request is accepted at a posedge when en=1 and busy=0. While busy=1, en is ignored.
- Offsets: off=addr[2:0]; idx=(addr-BASE_ADDR)>>3.
- In range: addr>=BASE_ADDR and idx<DEPTH_WORDS.
- Lane mask: lane=wen<<off, 16-bit intermediate. Lane-crossing if lane[15:8]!=0.
- Write (wen!=0) at accept edge T, legal:
  - mem[idx] byte k <= (wdata<<(8*off)) byte k for each k with lane[k]=1.
  - Completes in one cycle; no busy, no rvalid.
- Write, illegal (out of range or lane-crossing): no memory change; err=1 during cycle T+1.
- Read (wen==0): word=mem[idx] sampled at T. rdata=word>>(8*off), zero-filled on top.
  - Read out of range: rdata=0, err=1 together with rvalid.
  - Read data is never lane-checked. The memory stage extracts its width.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: read accepted with READ_LAT==1 -> RESP; with READ_LAT>1 -> WAIT, load cnt=READ_LAT-1.
  - WAIT: busy=1; cnt decrements each cycle; when cnt==1 -> RESP.
  - RESP: rvalid=1 and rdata valid for exactly that cycle; busy=0, so a new request can be accepted in the RESP cycle -> back-to-back throughput. No new request -> IDLE.
  - rdata holds its last value after rvalid drops.
- Latency: rvalid at cycle T+READ_LAT. Busy is high for cycles T+1..T+READ_LAT-1; never high when READ_LAT=1.
- Ordering:
  - A write at T followed by a read of the same word at T+1 returns the new data.
  - A read in WAIT returns the word sampled at acceptance, unaffected by later writes (none can be accepted anyway).
- Reset asserted during WAIT/RESP: pending read is dropped, no rvalid is produced, state=IDLE.
- en with X on addr while busy=1 must not corrupt state.

Optional Feature:
YSYX_22041752_DSRAM_CNT_EN
- Defined:
  - rd_cnt increments on each accepted read.
  - wr_cnt increments on each accepted legal write.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: both ports remain and are tied to 0; no counter flops are synthesised.

Test Plan:
- Write at addr=0x8000_0008, wen=8'hff, wdata=64'h1122_3344_5566_7788; read same addr next cycle -> rvalid at T+1 (READ_LAT=1), rdata=64'h1122_3344_5566_7788, busy stays 0.
- Write at addr=0x8000_0013, wen=8'h01, wdata=0xAB; read 0x8000_0010 -> byte 3 of rdata=0xAB, other bytes unchanged. Read 0x8000_0013 -> rdata=64'h..._00AB in low byte, upper bytes are the memory's bytes 4-7 shifted down.
- Write at addr=0x8000_0006, wen=8'h0f -> err pulses at T+1, memory word unchanged on readback.
- Read at addr=0x7FFF_FFF8 -> rvalid and err both 1 at T+READ_LAT, rdata=0.
- READ_LAT=3, read accepted at T -> busy=1 at T+1 and T+2, en ignored there, rvalid at T+3; a second read presented at T+3 is accepted and returns at T+6.
- READ_LAT=3, reset pulled low at T+1 -> rvalid never asserts, busy=0 immediately. With YSYX_22041752_DSRAM_CNT_EN defined: 5 reads + 2 legal writes + 1 illegal write -> rd_cnt=5, wr_cnt=2.
